fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the single-issue RV32I core. It owns the PC, issues one instruction-memory read at a time over a valid/ready request port, and parks the returned word in an IF/ID register. It classifies the opcode into the one-hot type flags (R, I, L, S, B, J, Jr, lui, aui) that feed the control-decode stage directly downstream. It also honours downstream stall and branch/jump redirect.

## Interface
- XLEN, 32, datapath/PC width
- RESET_PC, 32'h0000_0000, PC loaded on reset
- clk  in  1  core clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- imem_req_valid  out  1  read request valid
- imem_req_addr  out  XLEN  word address (bits [1:0] always 0)
- imem_req_ready  in  1  memory accepts request this cycle
- imem_rsp_valid  in  1  read data valid (exactly one per accepted request)
- imem_rsp_data  in  32  instruction word
- stall  in  1  downstream cannot accept; IF/ID holds
- redirect_valid  in  1  branch/jump taken; flush and refetch
- redirect_pc  in  XLEN  new PC; bits [1:0] ignored (forced 0)
- if_valid  out  1  IF/ID slot holds a live instruction
- if_pc  out  XLEN  PC of slot instruction
- if_instr  out  32  slot instruction word
- type_r, type_i, type_l, type_s, type_b, type_j, type_jr, type_lui, type_aui  out  1 each  one-hot opcode class, all 0 when if_valid=0
- illegal  out  1  if_valid=1 and opcode matches no class

## Operation
- FSM states: REQ, WAIT, HOLD. At most one outstanding request.
- REQ: imem_req_valid=1, addr=pc. On imem_req_ready, go to WAIT.
- WAIT: on imem_rsp_valid:
  - discard flag set: drop the word, clear discard, go to REQ.
  - slot free (if_valid=0 or stall=0): load slot, pc+=4, go to REQ.
  - otherwise: store the word in the park buffer, go to HOLD.
- HOLD: when stall=0, move the parked word to the slot, pc+=4, go to REQ.
- Slot is consumed by downstream on any cycle with if_valid=1 and stall=0. With no new word it clears if_valid, else it reloads.
- Redirect has highest priority. Next edge: pc=redirect_pc, if_valid=0, flags=0.
  - In WAIT: set discard.
  - In HOLD: drop the parked word, go to REQ.
  - In REQ with simultaneous ready: go to WAIT with discard set.
- Opcode decode (instr[6:0]): 0110011 R, 0010011 I, 0000011 L, 0100011 S, 1100011 B, 1101111 J, 1100111 Jr, 0110111 lui, 0010111 aui, else illegal. Decoded combinationally from the incoming word and registered with the slot.
- pc increments modulo 2^XLEN (wraps 0xFFFF_FFFC to 0).
- Reset values: state REQ, pc=RESET_PC, discard=0, if_valid=0, if_pc=0, if_instr=0, all flags and illegal 0. Reset mid-transaction abandons the request; a late response is ignored because state is REQ, not WAIT.

## Timing
- First cycle after reset deasserts: imem_req_valid=1, addr=RESET_PC.
- Response in cycle N (slot free): if_valid, if_pc, if_instr and flags valid from cycle N+1. Next request is issued in cycle N+1.
- Best-case throughput: one instruction per 2 cycles with a zero-wait memory.
- Redirect in cycle N: if_valid=0 in N+1. A request with the new PC is issued no earlier than N+1 (REQ/HOLD case) or the cycle after the discarded response (WAIT case).
- If redirect and stall are asserted together, redirect wins.
- All outputs are registered except imem_req_valid and imem_req_addr, which are decoded from state and pc with no input dependency.

## Structure
- Shared package riscv_pkg:
  - opcode localparams (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC)
  - fetch_state_t enum {REQ, WAIT, HOLD}
  - inst_type_t packed struct of the nine flags
- Sub-module inst_type_decode: combinational 7-bit opcode to inst_type_t plus illegal. It is reused by later decode stages.

## Test plan
- Reset with RESET_PC=0x100, zero-wait memory returning 0x00000033 -> request at 0x100 in cycle 1; if_valid=1, type_r=1, if_pc=0x100; next request at 0x104.
- stall held 5 cycles while a response for 0x104 (0x00000003) arrives -> FSM in HOLD, slot unchanged. After stall drops: if_pc=0x104, type_l=1, pc=0x108.
- redirect_valid to 0x200 while in WAIT -> if_valid=0 next cycle; the pending response is discarded and never appears; next request at 0x200.
- redirect_valid to 0x203 together with imem_req_ready in REQ -> discard is set; next request address is 0x200.
- Stream of all nine opcodes plus 0x0000007F -> exactly one matching flag per instruction; 0x7F gives illegal=1 with all flags 0.
- pc at 0xFFFF_FFFC fetched -> next request address is 0x0000_0000.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: base opcodes, fetch FSM states and the one-hot
// instruction-class flags passed from fetch to decode.
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        HOLD
    } fetch_state_t;

    typedef struct packed {
        logic r;
        logic i;
        logic l;
        logic s;
        logic b;
        logic j;
        logic jr;
        logic lui;
        logic aui;
    } inst_type_t;

endpackage

// File: rtl/inst_type_decode.sv
// Combinational opcode classifier: one-hot class flags, or illegal when the
// opcode belongs to none of the nine supported classes.
module inst_type_decode
    import riscv_pkg::*;
(
    input  logic [6:0] opcode,
    output inst_type_t inst_type,
    output logic       illegal
);

    always_comb begin
        inst_type = '0;
        illegal   = 1'b0;
        case (opcode)
            OP_R:      inst_type.r   = 1'b1;
            OP_I:      inst_type.i   = 1'b1;
            OP_LOAD:   inst_type.l   = 1'b1;
            OP_STORE:  inst_type.s   = 1'b1;
            OP_BRANCH: inst_type.b   = 1'b1;
            OP_JAL:    inst_type.j   = 1'b1;
            OP_JALR:   inst_type.jr  = 1'b1;
            OP_LUI:    inst_type.lui = 1'b1;
            OP_AUIPC:  inst_type.aui = 1'b1;
            default:   illegal       = 1'b1;
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, keeps one imem read in flight, and holds the
// returned word plus its decoded class in the IF/ID slot.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_instr,
    output logic            type_r,
    output logic            type_i,
    output logic            type_l,
    output logic            type_s,
    output logic            type_b,
    output logic            type_j,
    output logic            type_jr,
    output logic            type_lui,
    output logic            type_aui,
    output logic            illegal
);

    fetch_state_t    state_reg;
    logic [XLEN-1:0] pc_reg;
    logic            discard_reg;
    logic [31:0]     park_reg;
    logic            if_valid_reg;
    logic [XLEN-1:0] if_pc_reg;
    logic [31:0]     if_instr_reg;
    inst_type_t      type_reg;
    logic            illegal_reg;

    logic [31:0]     load_word;
    inst_type_t      dec_type;
    logic            dec_illegal;
    logic            slot_free;
    logic [XLEN-1:0] pc_inc;
    logic [XLEN-1:0] redirect_aligned;

    // The slot is fed either from the park buffer (HOLD) or straight off the bus.
    assign load_word        = (state_reg == HOLD) ? park_reg : imem_rsp_data;
    assign slot_free        = !if_valid_reg || !stall;
    assign pc_inc           = pc_reg + XLEN'(4);
    assign redirect_aligned = redirect_pc & ~XLEN'(3);

    inst_type_decode u_decode (
        .opcode    (load_word[6:0]),
        .inst_type (dec_type),
        .illegal   (dec_illegal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= REQ;
            pc_reg       <= RESET_PC;
            discard_reg  <= 1'b0;
            park_reg     <= '0;
            if_valid_reg <= 1'b0;
            if_pc_reg    <= '0;
            if_instr_reg <= '0;
            type_reg     <= '0;
            illegal_reg  <= 1'b0;
        end else if (redirect_valid) begin
            pc_reg       <= redirect_aligned;
            if_valid_reg <= 1'b0;
            type_reg     <= '0;
            illegal_reg  <= 1'b0;
            case (state_reg)
                REQ: begin
                    if (imem_req_ready) begin
                        state_reg   <= WAIT;
                        discard_reg <= 1'b1;
                    end
                end
                WAIT: begin
                    // A response landing with the redirect is the stale word itself,
                    // so nothing remains to discard afterwards.
                    if (imem_rsp_valid) begin
                        state_reg   <= REQ;
                        discard_reg <= 1'b0;
                    end else begin
                        discard_reg <= 1'b1;
                    end
                end
                default: state_reg <= REQ;
            endcase
        end else begin
            if (if_valid_reg && !stall) begin
                if_valid_reg <= 1'b0;
                type_reg     <= '0;
                illegal_reg  <= 1'b0;
            end
            case (state_reg)
                REQ: begin
                    if (imem_req_ready)
                        state_reg <= WAIT;
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        if (discard_reg) begin
                            discard_reg <= 1'b0;
                            state_reg   <= REQ;
                        end else if (slot_free) begin
                            if_valid_reg <= 1'b1;
                            if_pc_reg    <= pc_reg;
                            if_instr_reg <= load_word;
                            type_reg     <= dec_type;
                            illegal_reg  <= dec_illegal;
                            pc_reg       <= pc_inc;
                            state_reg    <= REQ;
                        end else begin
                            park_reg  <= imem_rsp_data;
                            state_reg <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        if_valid_reg <= 1'b1;
                        if_pc_reg    <= pc_reg;
                        if_instr_reg <= load_word;
                        type_reg     <= dec_type;
                        illegal_reg  <= dec_illegal;
                        pc_reg       <= pc_inc;
                        state_reg    <= REQ;
                    end
                end
                default: state_reg <= REQ;
            endcase
        end
    end

    assign imem_req_valid = (state_reg == REQ);
    assign imem_req_addr  = pc_reg;

    assign if_valid = if_valid_reg;
    assign if_pc    = if_pc_reg;
    assign if_instr = if_instr_reg;
    assign type_r   = type_reg.r;
    assign type_i   = type_reg.i;
    assign type_l   = type_reg.l;
    assign type_s   = type_reg.s;
    assign type_b   = type_reg.b;
    assign type_j   = type_reg.j;
    assign type_jr  = type_reg.jr;
    assign type_lui = type_reg.lui;
    assign type_aui = type_reg.aui;
    assign illegal  = illegal_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: hand-timed sequences for stall/redirect/wrap corners
// and a table-driven opcode stream checked through a scoreboard queue.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          NV     = 10;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        type_r, type_i, type_l, type_s, type_b;
    logic        type_j, type_jr, type_lui, type_aui;
    logic        illegal;
    logic [8:0]  flags;

    assign flags = {type_r, type_i, type_l, type_s, type_b, type_j, type_jr, type_lui, type_aui};

    typedef struct {
        logic [31:0] instr;
        logic [8:0]  flags;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [8:0]  flags;
        logic        ill;
    } sb_t;

    vec_t        vecs [NV];
    sb_t         sb_q [$];
    logic [31:0] mem [logic [31:0]];

    int          total;
    int          bad;
    int          popped;
    int          lat;
    bit          sb_en;
    bit          m_acc;
    bit          m_busy;
    bit          mon_pv;
    logic [31:0] m_acc_addr;
    logic [31:0] m_addr;
    int          m_cnt;

    fetch_stage #(
        .XLEN     (32),
        .RESET_PC (RST_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .type_r         (type_r),
        .type_i         (type_i),
        .type_l         (type_l),
        .type_s         (type_s),
        .type_b         (type_b),
        .type_j         (type_j),
        .type_jr        (type_jr),
        .type_lui       (type_lui),
        .type_aui       (type_aui),
        .illegal        (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem.exists(a))
            return mem[a];
        return 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: accepts every request, answers `lat` cycles after acceptance.
    task automatic mem_step();
        int idx;
        imem_rsp_valid = 1'b0;
        if (reset) begin
            m_busy = 1'b0;
            m_acc  = 1'b0;
        end else begin
            if (m_acc) begin
                m_busy = 1'b1;
                m_addr = m_acc_addr;
                m_cnt  = lat;
            end
            if (m_busy) begin
                if (m_cnt <= 1) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(m_addr);
                    m_busy         = 1'b0;
                    $display("rsp addr=%h data=%h", m_addr, imem_rsp_data);
                    if (sb_en && m_addr >= RST_PC && m_addr < RST_PC + 32'(4 * NV)) begin
                        idx = int'((m_addr - RST_PC) >> 2);
                        sb_q.push_back('{m_addr, vecs[idx].instr, vecs[idx].flags, vecs[idx].ill});
                    end
                end else begin
                    m_cnt--;
                end
            end
        end
        imem_req_ready = 1'b1;
        m_acc          = !reset && imem_req_valid;
        m_acc_addr     = imem_req_addr;
    endtask

    // Slot monitor: a new instruction appears when the slot was empty or consumed.
    task automatic mon_step();
        sb_t e;
        if (sb_en && !reset && if_valid && (!mon_pv || !stall) && popped < NV) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_load", 32'(if_valid), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("sb_pc", if_pc, e.pc);
                check("sb_instr", if_instr, e.instr);
                check("sb_flags", 32'(flags), 32'(e.flags));
                check("sb_illegal", 32'(illegal), 32'(e.ill));
                popped++;
            end
        end
        mon_pv = if_valid;
    endtask

    task automatic tick();
        mem_step();
        @(negedge clk);
        mon_step();
    endtask

    initial begin
        int n;
        total = 0; bad = 0; popped = 0; lat = 1;
        sb_en = 1'b0; m_acc = 1'b0; m_busy = 1'b0; mon_pv = 1'b0;
        m_acc_addr = '0; m_addr = '0; m_cnt = 0;
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;

        vecs[0] = '{32'h00B5_0533, 9'h100, 1'b0};
        vecs[1] = '{32'h0015_0513, 9'h080, 1'b0};
        vecs[2] = '{32'h0005_2583, 9'h040, 1'b0};
        vecs[3] = '{32'h00B5_2023, 9'h020, 1'b0};
        vecs[4] = '{32'h00B5_0463, 9'h010, 1'b0};
        vecs[5] = '{32'h0080_006F, 9'h008, 1'b0};
        vecs[6] = '{32'h0000_8067, 9'h004, 1'b0};
        vecs[7] = '{32'h1234_50B7, 9'h002, 1'b0};
        vecs[8] = '{32'h0000_1097, 9'h001, 1'b0};
        vecs[9] = '{32'h0000_007F, 9'h000, 1'b1};

        mem[32'h0000_0100] = 32'h0000_0033;
        mem[32'h0000_0104] = 32'h0000_0003;
        mem[32'h0000_0200] = 32'h0000_006F;

        repeat (3) tick();
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_if_pc", if_pc, 32'd0);
        check("rst_if_instr", if_instr, 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);

        reset = 1'b0;
        check("first_req_valid", 32'(imem_req_valid), 32'd1);
        check("first_req_addr", imem_req_addr, RST_PC);
        tick();
        check("wait_no_req", 32'(imem_req_valid), 32'd0);
        tick();
        check("r_if_valid", 32'(if_valid), 32'd1);
        check("r_flags", 32'(flags), 32'h100);
        check("r_if_pc", if_pc, 32'h100);
        check("r_if_instr", if_instr, 32'h33);
        check("r_next_req_valid", 32'(imem_req_valid), 32'd1);
        check("r_next_req_addr", imem_req_addr, 32'h104);

        // Response for 0x104 lands while downstream is stalled.
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_if_pc", if_pc, 32'h100);
            check("stall_if_valid", 32'(if_valid), 32'd1);
            check("stall_no_req", 32'(imem_req_valid), 32'd0);
        end
        stall = 1'b0;
        tick();
        check("hold_if_pc", if_pc, 32'h104);
        check("hold_if_instr", if_instr, 32'h3);
        check("hold_flags", 32'(flags), 32'h040);
        check("hold_req_addr", imem_req_addr, 32'h108);
        check("hold_req_valid", 32'(imem_req_valid), 32'd1);

        // Redirect while a slow response is outstanding, with stall also high.
        lat = 3;
        stall = 1'b1;
        tick();
        check("pre_redir_if_valid", 32'(if_valid), 32'd1);
        check("pre_redir_no_req", 32'(imem_req_valid), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0;
        stall = 1'b0;
        lat = 1;
        check("redir_wait_if_valid", 32'(if_valid), 32'd0);
        check("redir_wait_flags", 32'(flags), 32'd0);
        check("redir_wait_no_req", 32'(imem_req_valid), 32'd0);
        tick();
        check("redir_wait_still", 32'(imem_req_valid), 32'd0);
        tick();
        check("discard_if_valid", 32'(if_valid), 32'd0);
        check("discard_req_valid", 32'(imem_req_valid), 32'd1);
        check("discard_req_addr", imem_req_addr, 32'h200);
        tick();
        tick();
        check("j_if_pc", if_pc, 32'h200);
        check("j_flags", 32'(flags), 32'h008);

        // Redirect to a misaligned PC in the same cycle the request is accepted.
        check("req_redir_req_valid", 32'(imem_req_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h203;
        tick();
        redirect_valid = 1'b0;
        check("req_redir_if_valid", 32'(if_valid), 32'd0);
        check("req_redir_no_req", 32'(imem_req_valid), 32'd0);
        tick();
        check("req_redir_req_valid2", 32'(imem_req_valid), 32'd1);
        check("req_redir_addr", imem_req_addr, 32'h200);
        check("req_redir_no_slot", 32'(if_valid), 32'd0);
        tick();
        tick();
        check("req_redir_slot_valid", 32'(if_valid), 32'd1);
        check("req_redir_slot_pc", if_pc, 32'h200);

        // PC wrap at the top of the address space.
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        n = 0;
        while (!imem_req_valid && n < 10) begin tick(); n++; end
        check("wrap_req_seen", 32'(imem_req_valid), 32'd1);
        check("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        n = 0;
        while (!if_valid && n < 10) begin tick(); n++; end
        check("wrap_slot_seen", 32'(if_valid), 32'd1);
        check("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
        check("wrap_flags", 32'(flags), 32'h080);
        check("wrap_next_req_valid", 32'(imem_req_valid), 32'd1);
        check("wrap_next_req_addr", imem_req_addr, 32'h0);

        // Opcode stream from RESET_PC with random stalls, checked by the scoreboard.
        reset = 1'b1;
        sb_q.delete();
        for (int k = 0; k < NV; k++)
            mem[RST_PC + 32'(4 * k)] = vecs[k].instr;
        sb_en = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        n = 0;
        while (popped < NV && n < 400) begin
            stall = ($urandom_range(0, 3) == 0);
            tick();
            n++;
        end
        stall = 1'b0;
        sb_en = 1'b0;
        check("stream_count", 32'(popped), 32'(NV));
        check("stream_leftover", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
